// File: rtl/serv_pc_seq.sv
// Sequencer for the bit-serial PC-update datapath: fetch, decode-time flag
// capture, one 32-bit serial pass, then a one-cycle carry-clear gap.
module serv_pc_seq #(
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_halt,
    output logic o_ibus_cyc,
    input  logic i_ibus_ack,
    input  logic i_iscomp,
    input  logic i_jump,
    input  logic i_trap,
    input  logic i_stall,
    output logic o_pc_en,
    output logic o_cnt0,
    output logic o_cnt1,
    output logic o_cnt2,
    output logic o_cnt12to31,
    output logic o_jump,
    output logic o_trap,
    output logic o_iscomp,
    output logic o_busy,
    output logic o_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Lane advance per RUN cycle and the lane LSB index of the final cycle.
    localparam logic [4:0] STEP = 5'(B + 1);
    localparam logic [4:0] LAST = 5'(32 - W);

    state_t     state_r;
    state_t     state_nx_s;
    logic [4:0] cnt_r;
    logic [4:0] cnt_nx_s;
    logic       jump_r;
    logic       jump_nx_s;
    logic       trap_r;
    logic       trap_nx_s;
    logic       iscomp_r;
    logic       iscomp_nx_s;
    logic       run_nx_s;

    logic       ibus_cyc_r;
    logic       pc_en_r;
    logic       cnt0_r;
    logic       cnt1_r;
    logic       cnt2_r;
    logic       cnt12_r;
    logic       busy_r;
    logic       done_r;

    // Next-state, next-count and flag-capture logic.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        jump_nx_s   = jump_r;
        trap_nx_s   = trap_r;
        iscomp_nx_s = iscomp_r;
        case (state_r)
            ST_IDLE: begin
                if (i_run && !i_halt) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (i_ibus_ack) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (i_stall) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    jump_nx_s   = i_jump;
                    trap_nx_s   = i_trap;
                    iscomp_nx_s = i_iscomp;
                    cnt_nx_s    = 5'd0;
                    state_nx_s  = ST_RUN;
                end
            end
            ST_RUN: begin
                // The count wraps to zero after the last lane, ready for the next pass.
                cnt_nx_s = cnt_r + STEP;
                if (cnt_r == LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                jump_nx_s   = 1'b0;
                trap_nx_s   = 1'b0;
                iscomp_nx_s = 1'b0;
                cnt_nx_s    = 5'd0;
                if (i_run && !i_halt) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                jump_nx_s   = 1'b0;
                trap_nx_s   = 1'b0;
                iscomp_nx_s = 1'b0;
                cnt_nx_s    = 5'd0;
                state_nx_s  = ST_IDLE;
            end
        endcase
    end

    assign run_nx_s = (state_nx_s == ST_RUN);

    // State, count, latched flags and output registers decoded from the next state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            jump_r     <= 1'b0;
            trap_r     <= 1'b0;
            iscomp_r   <= 1'b0;
            ibus_cyc_r <= 1'b0;
            pc_en_r    <= 1'b0;
            cnt0_r     <= 1'b0;
            cnt1_r     <= 1'b0;
            cnt2_r     <= 1'b0;
            cnt12_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            jump_r     <= jump_nx_s;
            trap_r     <= trap_nx_s;
            iscomp_r   <= iscomp_nx_s;
            ibus_cyc_r <= (state_nx_s == ST_FETCH);
            pc_en_r    <= run_nx_s;
            cnt0_r     <= run_nx_s && (cnt_nx_s == 5'd0);
            cnt1_r     <= run_nx_s && (cnt_nx_s == 5'd1);
            cnt2_r     <= run_nx_s && (cnt_nx_s == 5'd2);
            cnt12_r    <= run_nx_s && (cnt_nx_s >= 5'd12);
            busy_r     <= (state_nx_s != ST_IDLE);
            done_r     <= (state_nx_s == ST_DONE);
        end
    end

    assign o_ibus_cyc  = ibus_cyc_r;
    assign o_pc_en     = pc_en_r;
    assign o_cnt0      = cnt0_r;
    assign o_cnt1      = cnt1_r;
    assign o_cnt2      = cnt2_r;
    assign o_cnt12to31 = cnt12_r;
    assign o_jump      = jump_r;
    assign o_trap      = trap_r;
    assign o_iscomp    = iscomp_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

endmodule
